coffee_dispenser: RTL and testbench

Downstream stage of the `coffee` vending controller. It consumes the controller's `sale` and `ret` strobes. Each `sale` runs a timed brew sequence: cup drop, powder, hot water. Each `ret` queues one 100-won coin for the return solenoid, which drains the queue at a fixed pulse/gap cadence. The brew and return channels are independent and run concurrently.

---
 rtl/coffee_pkg.sv | 35 +++
 rtl/coffee_ret_unit.sv | 99 +++++++++
 rtl/coffee_dispenser.sv | 139 +++++++++++++
 tb/tb_coffee_dispenser.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/coffee_pkg.sv
// rtl/coffee_pkg.sv - shared state encodings and default timing for the coffee dispenser
package coffee_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CUP,
    POWDER,
    WATER,
    DONE
  } brew_state_e;

  typedef enum logic [1:0] {
    RIDLE,
    RPULSE,
    RGAP
  } ret_state_e;

  localparam int CUP_CYC_DEF    = 4;
  localparam int POWDER_CYC_DEF = 3;
  localparam int WATER_CYC_DEF  = 8;
  localparam int RET_CYC_DEF    = 2;
  localparam int RET_GAP_DEF    = 2;
  localparam int RET_W_DEF      = 3;

  function automatic int max5(input int a, input int b, input int c, input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/coffee_ret_unit.sv
// rtl/coffee_ret_unit.sv - coin return channel: pending counter, pulse/gap FSM, saturation error
module coffee_ret_unit
  import coffee_pkg::*;
#(
  parameter int RET_CYC = RET_CYC_DEF,
  parameter int RET_GAP = RET_GAP_DEF,
  parameter int RET_W   = RET_W_DEF,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ret_i,
  output logic             coin_ret_o,
  output logic [RET_W-1:0] ret_pend_o,
  output logic             err_o
);

  localparam logic [RET_W-1:0] PEND_MAX = '1;

  ret_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RET_W-1:0] pend_q, pend_d;
  logic             err_q, err_d;
  logic             coin_q, coin_d;
  logic             dec;

  assign dec = (state_q == RGAP) && (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RIDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      err_q   <= 1'b0;
      coin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      coin_q  <= coin_d;
    end
  end

  always_comb begin
    pend_d  = pend_q;
    err_d   = err_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    // A request and a retirement in the same cycle cancel out.
    case ({ret_i, dec})
      2'b10: begin
        if (pend_q == PEND_MAX) err_d = 1'b1;
        else                    pend_d = pend_q + 1'b1;
      end
      2'b01:   pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase
    case (state_q)
      RIDLE: begin
        if (pend_q != '0) begin
          state_d = RPULSE;
          cnt_d   = CNT_W'(RET_CYC - 1);
        end
      end
      RPULSE: begin
        if (cnt_q == '0) begin
          state_d = RGAP;
          cnt_d   = CNT_W'(RET_GAP - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RGAP: begin
        // Chain straight into the next pulse so the cadence stays RET_CYC+RET_GAP.
        if (cnt_q == '0) begin
          if (pend_d != '0) begin
            state_d = RPULSE;
            cnt_d   = CNT_W'(RET_CYC - 1);
          end else begin
            state_d = RIDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = RIDLE;
    endcase
  end

  always_comb begin
    coin_d = (state_d == RPULSE);
  end

  assign coin_ret_o = coin_q;
  assign ret_pend_o = pend_q;
  assign err_o      = err_q;

endmodule

// File: rtl/coffee_dispenser.sv
// rtl/coffee_dispenser.sv - brew sequencer with one-deep sale queue plus coin return channel
module coffee_dispenser
  import coffee_pkg::*;
#(
  parameter int CUP_CYC    = CUP_CYC_DEF,
  parameter int POWDER_CYC = POWDER_CYC_DEF,
  parameter int WATER_CYC  = WATER_CYC_DEF,
  parameter int RET_CYC    = RET_CYC_DEF,
  parameter int RET_GAP    = RET_GAP_DEF,
  parameter int RET_W      = RET_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sale,
  input  logic             ret,
  output logic             cup_o,
  output logic             powder_o,
  output logic             water_o,
  output logic             coin_ret_o,
  output logic             busy,
  output logic             done,
  output logic [RET_W-1:0] ret_pend,
  output logic             err
);

  localparam int CNT_W = $clog2(max5(CUP_CYC, POWDER_CYC, WATER_CYC, RET_CYC, RET_GAP)) + 1;

  brew_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sale_q, sale_d;
  logic             berr_q, berr_d;
  logic             cup_q, powder_q, water_q, done_q, busy_q;
  logic             cup_d, powder_d, water_d, done_d, busy_d;
  logic             ret_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sale_q   <= 1'b0;
      berr_q   <= 1'b0;
      cup_q    <= 1'b0;
      powder_q <= 1'b0;
      water_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sale_q   <= sale_d;
      berr_q   <= berr_d;
      cup_q    <= cup_d;
      powder_q <= powder_d;
      water_q  <= water_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sale_d  = sale_q;
    berr_d  = berr_q;
    if (state_q != IDLE && sale) begin
      if (sale_q) berr_d = 1'b1;
      else        sale_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (sale) begin
          state_d = CUP;
          cnt_d   = CNT_W'(CUP_CYC - 1);
        end
      end
      CUP: begin
        if (cnt_q == '0) begin
          state_d = POWDER;
          cnt_d   = CNT_W'(POWDER_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      POWDER: begin
        if (cnt_q == '0) begin
          state_d = WATER;
          cnt_d   = CNT_W'(WATER_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WATER: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d = cnt_q - 1'b1;
      end
      DONE: begin
        // A sale seen during DONE itself is consumed here rather than idling first.
        if (sale_q || sale) begin
          state_d = CUP;
          cnt_d   = CNT_W'(CUP_CYC - 1);
          sale_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cup_d    = (state_d == CUP);
    powder_d = (state_d == POWDER);
    water_d  = (state_d == WATER);
    done_d   = (state_d == DONE);
    busy_d   = (state_d != IDLE) || sale_d;
  end

  coffee_ret_unit #(
    .RET_CYC (RET_CYC),
    .RET_GAP (RET_GAP),
    .RET_W   (RET_W),
    .CNT_W   (CNT_W)
  ) u_ret (
    .clk        (CLK),
    .rst        (RST),
    .ret_i      (ret),
    .coin_ret_o (coin_ret_o),
    .ret_pend_o (ret_pend),
    .err_o      (ret_err)
  );

  assign cup_o    = cup_q;
  assign powder_o = powder_q;
  assign water_o  = water_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign err      = berr_q | ret_err;

endmodule

// File: tb/tb_coffee_dispenser.sv
// tb/tb_coffee_dispenser.sv - randomized and directed bench for coffee_dispenser against a timeline model
module tb_coffee_dispenser;
  import coffee_pkg::*;

  localparam int C     = CUP_CYC_DEF;
  localparam int P     = POWDER_CYC_DEF;
  localparam int W     = WATER_CYC_DEF;
  localparam int RC    = RET_CYC_DEF;
  localparam int RG    = RET_GAP_DEF;
  localparam int RW    = RET_W_DEF;
  localparam int TOTAL = C + P + W + 1;
  localparam int PMAX  = (1 << RW) - 1;

  logic          CLK = 1'b0;
  logic          RST, sale, ret;
  logic          cup_o, powder_o, water_o, coin_ret_o, busy, done, err;
  logic [RW-1:0] ret_pend;

  int vectors = 0;
  int miscompares = 0;

  // Model: brew position in its timeline, one queued sale, coins owed and position in the coin slot.
  int bt, pend, rt;
  bit bact, bq, berr, ract, rerr;

  coffee_dispenser dut (
    .CLK(CLK), .RST(RST), .sale(sale), .ret(ret),
    .cup_o(cup_o), .powder_o(powder_o), .water_o(water_o), .coin_ret_o(coin_ret_o),
    .busy(busy), .done(done), .ret_pend(ret_pend), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    bt = 0; bact = 0; bq = 0; berr = 0;
    pend = 0; rt = 0; ract = 0; rerr = 0;
  endtask

  task automatic model_step(input bit s, input bit r);
    bit dec;
    int np;
    if (!bact) begin
      if (s) begin bact = 1; bt = 0; end
    end else if (bt == TOTAL - 1) begin
      if (bq && s) berr = 1;
      if (bq || s) begin bt = 0; bq = 0; end
      else bact = 0;
    end else begin
      if (s) begin
        if (bq) berr = 1;
        else    bq = 1;
      end
      bt++;
    end
    dec = ract && (rt == RC + RG - 1);
    np  = pend;
    if (r && !dec) begin
      if (pend == PMAX) rerr = 1;
      else              np = pend + 1;
    end else if (dec && !r) begin
      np = pend - 1;
    end
    if (dec) begin
      if (np > 0) rt = 0;
      else        ract = 0;
    end else if (ract) begin
      rt++;
    end else if (pend > 0) begin
      ract = 1; rt = 0;
    end
    pend = np;
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) model_reset();
    else     model_step(sale, ret);
  end

  always @(negedge CLK) begin
    check("cup_o",      cup_o,      bact && bt < C);
    check("powder_o",   powder_o,   bact && bt >= C && bt < C + P);
    check("water_o",    water_o,    bact && bt >= C + P && bt < C + P + W);
    check("done",       done,       bact && bt == TOTAL - 1);
    check("busy",       busy,       bact || bq);
    check("coin_ret_o", coin_ret_o, ract && rt < RC);
    check("ret_pend",   ret_pend,   pend);
    check("err",        err,        berr || rerr);
  end

  task automatic pulse_rst();
    @(negedge CLK); #2 RST = 1'b1;
    @(negedge CLK); #2 RST = 1'b0;
  endtask

  int nd, nc, k;
  bit prev, found;
  int ps, pr;

  initial begin
    RST = 1'b1; sale = 1'b0; ret = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_pend", ret_pend, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    #2 RST = 1'b0;

    // Single brew timeline.
    repeat (4) @(negedge CLK);
    sale = 1'b1;
    @(negedge CLK); sale = 1'b0;
    check("brew_cup_first", cup_o, 1);
    repeat (3) @(negedge CLK);
    check("brew_cup_last", cup_o, 1);
    @(negedge CLK);
    check("brew_cup_off", cup_o, 0);
    check("brew_powder_first", powder_o, 1);
    repeat (2) @(negedge CLK);
    check("brew_powder_last", powder_o, 1);
    @(negedge CLK);
    check("brew_water_first", water_o, 1);
    repeat (7) @(negedge CLK);
    check("brew_water_last", water_o, 1);
    @(negedge CLK);
    check("brew_done", done, 1);
    @(negedge CLK);
    check("brew_done_off", done, 0);
    check("brew_idle", busy, 0);

    // Back-to-back brew queued during WATER.
    sale = 1'b1;
    @(negedge CLK); sale = 1'b0;
    repeat (8) @(negedge CLK);
    check("b2b_in_water", water_o, 1);
    sale = 1'b1;
    @(negedge CLK); sale = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (done) found = 1;
      else @(negedge CLK);
    end
    check("b2b_done_seen", found, 1);
    @(negedge CLK);
    check("b2b_cup_next", cup_o, 1);
    check("b2b_busy", busy, 1);
    check("b2b_err", err, 0);
    repeat (25) @(negedge CLK);

    // Three sales in one brew: one queued, one dropped.
    sale = 1'b1; @(negedge CLK); sale = 1'b0;
    @(negedge CLK); sale = 1'b1; @(negedge CLK); sale = 1'b0;
    @(negedge CLK); sale = 1'b1; @(negedge CLK); sale = 1'b0;
    nd = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) nd++;
      @(negedge CLK);
    end
    check("three_sale_dones", nd, 2);
    check("three_sale_err", err, 1);

    pulse_rst();

    // Three consecutive coin requests.
    @(negedge CLK); ret = 1'b1;
    @(negedge CLK);
    check("ret3_pend1", ret_pend, 1);
    @(negedge CLK);
    check("ret3_pend2", ret_pend, 2);
    check("ret3_coin_rise", coin_ret_o, 1);
    @(negedge CLK); ret = 1'b0;
    check("ret3_pend3", ret_pend, 3);
    nc = 1; prev = coin_ret_o;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (coin_ret_o && !prev) nc++;
      prev = coin_ret_o;
    end
    check("ret3_pulses", nc, 3);
    check("ret3_drained", ret_pend, 0);
    check("ret3_err", err, 0);

    // Saturation: nine requests, one retires mid-burst, one is dropped.
    ret = 1'b1;
    nc = 0; prev = 1'b0;
    for (k = 0; k < 9; k++) begin
      @(negedge CLK);
      if (coin_ret_o && !prev) nc++;
      prev = coin_ret_o;
      if (k == 4) check("sat_pend5", ret_pend, 5);
      if (k == 5) check("sat_coincide", ret_pend, 5);
    end
    ret = 1'b0;
    check("sat_pend7", ret_pend, 7);
    check("sat_err", err, 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (coin_ret_o && !prev) nc++;
      prev = coin_ret_o;
    end
    check("sat_pulses", nc, 8);
    check("sat_drained", ret_pend, 0);

    pulse_rst();

    // Reset during POWDER with two coins owed.
    @(negedge CLK); sale = 1'b1; ret = 1'b1;
    @(negedge CLK); sale = 1'b0;
    @(negedge CLK); ret = 1'b0;
    check("rstmid_pend2", ret_pend, 2);
    repeat (3) @(negedge CLK);
    check("rstmid_powder", powder_o, 1);
    #1 RST = 1'b1;
    #1;
    check("rstmid_powder0", powder_o, 0);
    check("rstmid_coin0", coin_ret_o, 0);
    check("rstmid_pend0", ret_pend, 0);
    check("rstmid_busy0", busy, 0);
    check("rstmid_all0", {cup_o, water_o, done, err}, 0);
    @(negedge CLK); #2 RST = 1'b0;
    nc = 0; nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (coin_ret_o) nc++;
      if (done) nd++;
    end
    check("rstmid_no_coin", nc, 0);
    check("rstmid_no_done", nd, 0);

    // Randomized traffic with varying densities and occasional resets.
    for (int blk = 0; blk < 6; blk++) begin
      ps = $urandom_range(2, 30);
      pr = $urandom_range(2, 45);
      for (int i = 0; i < 500; i++) begin
        @(negedge CLK);
        sale = ($urandom_range(0, 99) < ps);
        ret  = ($urandom_range(0, 99) < pr);
        #2 RST = ($urandom_range(0, 399) == 0);
      end
    end
    @(negedge CLK); sale = 1'b0; ret = 1'b0; #2 RST = 1'b0;
    repeat (60) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
